// File: rtl/fetch_branch_ctrl_if.sv
// Handshake and bus bundle between the fetch/branch controller and its driver.
// The master side drives run control and LUT programming; the slave is the controller.
interface fetch_branch_ctrl_if #(
    parameter int L     = 10,
    parameter int LUT_W = 8
);
    logic             Start;
    logic [8:0]       Instr;
    logic             CondFlag;
    logic             LutWe;
    logic [4:0]       LutAddr;
    logic [LUT_W-1:0] LutData;
    logic             En;
    logic             BranchEn;
    logic [L-1:0]     Offset;
    logic             Done;
    logic [15:0]      CycleCount;

    modport master (
        output Start,
        output Instr,
        output CondFlag,
        output LutWe,
        output LutAddr,
        output LutData,
        input  En,
        input  BranchEn,
        input  Offset,
        input  Done,
        input  CycleCount
    );

    modport slave (
        input  Start,
        input  Instr,
        input  CondFlag,
        input  LutWe,
        input  LutAddr,
        input  LutData,
        output En,
        output BranchEn,
        output Offset,
        output Done,
        output CycleCount
    );
endinterface

// File: rtl/fetch_branch_ctrl.sv
// PC sequencer and branch resolver: run control, 32-entry offset LUT, HALT detection.
// Optional RUN-cycle counter enabled by defining FETCH_CYCLE_COUNT_EN.
module fetch_branch_ctrl #(
    parameter int         L     = 10,
    parameter int         LUT_W = 8,
    parameter logic [8:0] HALT  = 9'h1FF
) (
    input logic                Clk,
    input logic                Reset,
    fetch_branch_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN,
        HALTED
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [LUT_W-1:0] lut_q [32];
    logic [LUT_W-1:0] lut_rd;
    logic             is_branch;

    assign lut_rd    = lut_q[bus.Instr[4:0]];
    assign is_branch = (bus.Instr[8:6] == 3'b110);

    // State register; reset dominates all other inputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and run outputs; branch resolution is combinational.
    always_comb begin
        state_d      = state_q;
        bus.En       = 1'b0;
        bus.Done     = 1'b0;
        bus.BranchEn = 1'b0;
        bus.Offset   = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (!bus.Start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                bus.En = 1'b1;
                if (is_branch && bus.CondFlag) begin
                    bus.BranchEn = 1'b1;
                    bus.Offset   = L'($signed(lut_rd));
                end
                if (bus.Instr == HALT) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                bus.Done = 1'b1;
                if (bus.Start) begin
                    state_d = ARM;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Offset LUT: synchronous write, reads see the pre-write contents.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) begin
                lut_q[i] <= '0;
            end
        end else if (bus.LutWe) begin
            lut_q[bus.LutAddr] <= bus.LutData;
        end
    end

`ifdef FETCH_CYCLE_COUNT_EN
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Counter next value: clear on launch, saturating count while running.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ARM && state_d == RUN) begin
            cnt_d = '0;
        end else if (state_q == RUN && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.CycleCount = cnt_q;
`else
    assign bus.CycleCount = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_branch_ctrl.sv
// Scoreboard bench for fetch_branch_ctrl: directed scenarios then random traffic.
// Expected outputs are queued at drive time and checked by a negedge monitor.
module tb_fetch_branch_ctrl;

    logic Clk;
    logic Reset;

    fetch_branch_ctrl_if #(.L(10), .LUT_W(8)) bus ();

    fetch_branch_ctrl #(.L(10), .LUT_W(8), .HALT(9'h1FF)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        en;
        logic        br;
        logic [9:0]  off;
        logic        done;
        logic [15:0] cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_total;
    int   n_pass;
    bit   mon_on;

    // Reference model: run phase flags, offset table, run-cycle tally.
    bit          m_arm;
    bit          m_run;
    bit          m_fin;
    int          m_cnt;
    logic [7:0]  m_lut [32];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (mon_on) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL scoreboard: queue empty at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("En", 16'(bus.En), 16'(e.en));
                check("BranchEn", 16'(bus.BranchEn), 16'(e.br));
                check("Offset", 16'(bus.Offset), 16'(e.off));
                check("Done", 16'(bus.Done), 16'(e.done));
                check("CycleCount", bus.CycleCount, e.cyc);
            end
        end
    end

    // One clock cycle: drive inputs, queue the expected outputs, advance the model.
    task automatic step(input bit rst, input bit s, input logic [8:0] ins, input bit c,
                        input bit we, input logic [4:0] a, input logic [7:0] d);
        exp_t e;
        bit   taken;
        int   sx;
        Reset        = rst;
        bus.Start    = s;
        bus.Instr    = ins;
        bus.CondFlag = c;
        bus.LutWe    = we;
        bus.LutAddr  = a;
        bus.LutData  = d;
        taken = m_run && (ins >= 9'h180) && (ins < 9'h1C0) && c;
        sx = int'($signed(m_lut[ins[4:0]]));
        if (sx < 0) sx = sx + 1024;
        e.en   = m_run;
        e.br   = taken;
        e.off  = taken ? 10'(sx) : 10'd0;
        e.done = m_fin;
`ifdef FETCH_CYCLE_COUNT_EN
        e.cyc  = 16'(m_cnt);
`else
        e.cyc  = 16'h0000;
`endif
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
        if (rst) begin
            m_arm = 0;
            m_run = 0;
            m_fin = 0;
            m_cnt = 0;
            for (int i = 0; i < 32; i++) m_lut[i] = 8'h00;
        end else begin
            if (we) m_lut[a] = d;
            if (m_run) begin
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
                if (ins == 9'h1FF) begin
                    m_run = 0;
                    m_fin = 1;
                end
            end else if (m_arm) begin
                if (!s) begin
                    m_arm = 0;
                    m_run = 1;
                    m_cnt = 0;
                end
            end else if (m_fin) begin
                if (s) begin
                    m_fin = 0;
                    m_arm = 1;
                end
            end else if (s) begin
                m_arm = 1;
            end
        end
    endtask

    task automatic launch();
        repeat (3) step(0, 1, 9'h000, 0, 0, 5'd0, 8'h00);
        step(0, 0, 9'h000, 0, 0, 5'd0, 8'h00);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        mon_on  = 0;
        m_arm   = 0;
        m_run   = 0;
        m_fin   = 0;
        m_cnt   = 0;
        for (int i = 0; i < 32; i++) m_lut[i] = 8'h00;
        Reset        = 1;
        bus.Start    = 0;
        bus.Instr    = 9'h000;
        bus.CondFlag = 0;
        bus.LutWe    = 0;
        bus.LutAddr  = 5'd0;
        bus.LutData  = 8'h00;
        repeat (2) @(posedge Clk);
        #1;
        mon_on = 1;

        // reset state, branch word ignored outside RUN
        step(1, 0, 9'h180, 1, 0, 5'd0, 8'h00);
        step(0, 0, 9'h180, 1, 0, 5'd0, 8'h00);

        // launch on Start fall, run, HALT
        launch();
        step(0, 0, 9'h001, 0, 0, 5'd0, 8'h00);
        step(0, 0, 9'h002, 1, 0, 5'd0, 8'h00);
        step(0, 0, 9'h1FF, 1, 0, 5'd0, 8'h00);
        step(0, 0, 9'h000, 0, 0, 5'd0, 8'h00);

        // negative offset, taken and not taken, then same-cycle write
        step(0, 0, 9'h000, 0, 1, 5'd3, 8'hFB);
        step(0, 1, 9'h000, 0, 0, 5'd0, 8'h00);
        step(0, 0, 9'h000, 0, 0, 5'd0, 8'h00);
        step(0, 0, 9'h183, 1, 0, 5'd0, 8'h00);
        step(0, 0, 9'h183, 0, 0, 5'd0, 8'h00);
        step(0, 0, 9'h187, 1, 1, 5'd7, 8'h04);
        step(0, 0, 9'h187, 1, 0, 5'd0, 8'h00);
        step(0, 0, 9'h1FF, 0, 0, 5'd0, 8'h00);
        step(0, 0, 9'h000, 0, 0, 5'd0, 8'h00);

        // restart from HALTED: 20-cycle run with retained LUT
        step(0, 1, 9'h000, 0, 0, 5'd0, 8'h00);
        step(0, 0, 9'h000, 0, 0, 5'd0, 8'h00);
        step(0, 0, 9'h183, 1, 0, 5'd0, 8'h00);
        for (int i = 0; i < 18; i++) step(0, 1, 9'(i), 0, 0, 5'd0, 8'h00);
        step(0, 0, 9'h1FF, 0, 0, 5'd0, 8'h00);
        repeat (2) step(0, 0, 9'h000, 0, 0, 5'd0, 8'h00);

        // reset mid-run with branch pending
        launch();
        step(0, 0, 9'h187, 1, 0, 5'd0, 8'h00);
        step(1, 0, 9'h183, 1, 0, 5'd0, 8'h00);
        step(0, 0, 9'h183, 1, 0, 5'd0, 8'h00);
        step(0, 0, 9'h1FF, 1, 0, 5'd0, 8'h00);

        // random traffic
        begin
            bit s;
            s = 0;
            for (int i = 0; i < 800; i++) begin
                logic [8:0] ins;
                if ($urandom_range(0, 3) == 0) s = ~s;
                ins = 9'($urandom);
                if ($urandom_range(0, 15) == 0) ins = 9'h1FF;
                else if ($urandom_range(0, 2) == 0) ins = {3'b110, 6'($urandom)};
                step(($urandom_range(0, 99) == 0), s, ins, 1'($urandom),
                     ($urandom_range(0, 3) == 0), 5'($urandom), 8'($urandom));
            end
        end

        @(negedge Clk);
        mon_on = 0;
        #1;
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard: %0d entries left", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
